// File: rtl/pcm_mix_n_if.sv
// Bus bundle for the N-channel PCM mixer: strobe/sample/gain inputs and mixed-sample outputs.
// clip_count exists only when PCM_MIX_CLIP_CNT_EN is defined.
interface pcm_mix_n_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PCM_W    = 16,
  parameter int unsigned GAIN_W   = 8
);
  localparam int unsigned SelW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                         sample_strobe;
  logic [CHANNELS*PCM_W-1:0]    pcm_in;
  logic                         gain_we;
  logic [SelW-1:0]              gain_sel;
  logic [GAIN_W-1:0]            gain_data;
  logic                         overrun_clr;
  logic signed [PCM_W-1:0]      pcm_out;
  logic                         pcm_valid;
  logic                         clip;
  logic                         busy;
  logic                         overrun;
`ifdef PCM_MIX_CLIP_CNT_EN
  logic [15:0]                  clip_count;
`else
  // No clip counter in this build.
`endif

  modport master (
    output sample_strobe, pcm_in, gain_we, gain_sel, gain_data, overrun_clr,
    input  pcm_out, pcm_valid, clip, busy, overrun
`ifdef PCM_MIX_CLIP_CNT_EN
    , input clip_count
`endif
  );

  modport slave (
    input  sample_strobe, pcm_in, gain_we, gain_sel, gain_data, overrun_clr,
    output pcm_out, pcm_valid, clip, busy, overrun
`ifdef PCM_MIX_CLIP_CNT_EN
    , output clip_count
`endif
  );
endinterface

// File: rtl/pcm_mix_n.sv
// N-channel PCM mixer: snapshot on strobe, one multiply-accumulate per clock, saturate, emit.
// Optional saturating clip counter enabled by defining PCM_MIX_CLIP_CNT_EN.
module pcm_mix_n #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PCM_W    = 16,
  parameter int unsigned GAIN_W   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  pcm_mix_n_if.slave  bus_io
);
  localparam int unsigned SelW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ProdW = PCM_W + GAIN_W + 1;
  localparam int unsigned AccW  = PCM_W + GAIN_W + $clog2(CHANNELS) + 1;
  localparam int unsigned Shift = GAIN_W - 2;

  localparam logic [GAIN_W-1:0]      Unity = GAIN_W'(1) << Shift;
  localparam logic signed [AccW-1:0] MaxV  = {{(AccW-PCM_W+1){1'b0}}, {(PCM_W-1){1'b1}}};
  localparam logic signed [AccW-1:0] MinV  = {{(AccW-PCM_W+1){1'b1}}, {(PCM_W-1){1'b0}}};

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e                   state_q;
  logic [GAIN_W-1:0]        gain_q      [CHANNELS];
  logic signed [PCM_W-1:0]  snap_pcm_q  [CHANNELS];
  logic [GAIN_W-1:0]        snap_gain_q [CHANNELS];
  logic signed [AccW-1:0]   acc_q;
  logic [SelW-1:0]          idx_q;
  logic signed [PCM_W-1:0]  pcm_out_q;
  logic                     valid_q;
  logic                     clip_q;
  logic                     overrun_q;

  logic signed [ProdW-1:0]  pcm_ext;
  logic signed [ProdW-1:0]  gain_ext;
  logic signed [ProdW-1:0]  prod;
  logic signed [AccW-1:0]   sum;
  logic signed [AccW-1:0]   shifted;
  logic signed [PCM_W-1:0]  sat;
  logic                     sat_hit;
  logic                     last;
  logic                     finish;

  // Signed sample times zero-extended gain, then scale back out of Q2.(GAIN_W-2).
  always_comb begin
    pcm_ext  = ProdW'(snap_pcm_q[idx_q]);
    gain_ext = ProdW'({1'b0, snap_gain_q[idx_q]});
    prod     = pcm_ext * gain_ext;
    sum      = acc_q + AccW'(prod);
    shifted  = sum >>> Shift;
    sat_hit  = 1'b0;
    if (shifted > MaxV) begin
      sat     = {1'b0, {(PCM_W-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (shifted < MinV) begin
      sat     = {1'b1, {(PCM_W-1){1'b0}}};
      sat_hit = 1'b1;
    end else begin
      sat = shifted[PCM_W-1:0];
    end
  end

  assign last   = (idx_q == SelW'(CHANNELS - 1));
  assign finish = (state_q == StAcc) && last;

  // Live gain registers; writes land any time and only affect the next snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(CHANNELS); k++) gain_q[k] <= Unity;
    end else if (bus_io.gain_we && (int'(bus_io.gain_sel) < int'(CHANNELS))) begin
      gain_q[bus_io.gain_sel] <= bus_io.gain_data;
    end
  end

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else if (bus_io.sample_strobe && (state_q == StAcc)) begin
      overrun_q <= 1'b1;
    end else if (bus_io.overrun_clr) begin
      overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      idx_q     <= '0;
      pcm_out_q <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      for (int k = 0; k < int'(CHANNELS); k++) begin
        snap_pcm_q[k]  <= '0;
        snap_gain_q[k] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.sample_strobe) begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
              snap_pcm_q[k]  <= bus_io.pcm_in[k*PCM_W +: PCM_W];
              snap_gain_q[k] <= gain_q[k];
            end
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= StAcc;
          end
        end
        StAcc: begin
          acc_q <= sum;
          if (last) begin
            pcm_out_q <= sat;
            valid_q   <= 1'b1;
            clip_q    <= sat_hit;
            idx_q     <= '0;
            state_q   <= StIdle;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.pcm_out   = pcm_out_q;
  assign bus_io.pcm_valid = valid_q;
  assign bus_io.clip      = clip_q;
  assign bus_io.busy      = (state_q == StAcc);
  assign bus_io.overrun   = overrun_q;

`ifdef PCM_MIX_CLIP_CNT_EN
  logic [15:0] clip_cnt_q;

  // Clear takes priority over a simultaneous clipped result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip_cnt_q <= '0;
    end else if (bus_io.overrun_clr) begin
      clip_cnt_q <= '0;
    end else if (finish && sat_hit && (clip_cnt_q != 16'hffff)) begin
      clip_cnt_q <= clip_cnt_q + 16'd1;
    end
  end

  assign bus_io.clip_count = clip_cnt_q;
`else
  logic unused_finish;
  assign unused_finish = finish;
`endif
endmodule

// File: tb/tb_pcm_mix_n.sv
// Scoreboard bench for pcm_mix_n: directed test-plan cases plus randomized strobes/gains.
module tb_pcm_mix_n;
  localparam int unsigned CH = 4;
  localparam int unsigned PW = 16;
  localparam int unsigned GW = 8;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pcm_mix_n_if #(.CHANNELS(CH), .PCM_W(PW), .GAIN_W(GW)) bus ();

  pcm_mix_n #(.CHANNELS(CH), .PCM_W(PW), .GAIN_W(GW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_io (bus)
  );

  typedef struct {
    int val;
    bit clp;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edges = 0;
  int   mgain[CH];
  int   chv[CH];
  int   last_acc = -100;
  bit   m_ov = 1'b0;
  int   m_cc = 0;
  int   cc_clr_edge = -1;
  exp_t e;
  bit   mb;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edges);
    end
  endtask

  // Reference: dot product of samples and gains, floor-divide by unity, clamp to PCM range.
  function automatic void model_mix(output int v, output bit c);
    longint s = 0;
    for (int k = 0; k < int'(CH); k++) s += longint'(chv[k]) * longint'(mgain[k]);
    s = s >>> (GW - 2);
    c = 1'b1;
    if (s > 32767) v = 32767;
    else if (s < -32768) v = -32768;
    else begin
      v = int'(s);
      c = 1'b0;
    end
  endfunction

  task automatic model_reset();
    sb.delete();
    for (int k = 0; k < int'(CH); k++) mgain[k] = 64;
    last_acc = -100;
    m_ov = 1'b0;
    m_cc = 0;
  endtask

  // One clock: drive inputs, let the edge happen, then advance the model for that edge.
  task automatic step(input bit stb, input bit we = 1'b0, input int sel = 0,
                      input int gd = 0, input bit oclr = 1'b0);
    int  ed;
    bit  rej;
    exp_t x;
    bus.sample_strobe = stb;
    bus.gain_we       = we;
    bus.gain_sel      = SW'(sel);
    bus.gain_data     = GW'(gd);
    bus.overrun_clr   = oclr;
    for (int k = 0; k < int'(CH); k++) bus.pcm_in[k*PW +: PW] = PW'(chv[k]);
    ed = edges + 1;
    @(posedge clk);
    rej = 1'b0;
    if (stb) begin
      if (ed > last_acc + int'(CH)) begin
        model_mix(x.val, x.clp);
        x.due = ed + int'(CH);
        sb.push_back(x);
        last_acc = ed;
      end else begin
        rej = 1'b1;
      end
    end
    if (rej) m_ov = 1'b1;
    else if (oclr) m_ov = 1'b0;
    if (oclr) begin
      m_cc = 0;
      cc_clr_edge = ed;
    end
    if (we && sel < int'(CH)) mgain[sel] = gd;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic set_ch(input int a, input int b, input int c, input int d);
    chv[0] = a; chv[1] = b; chv[2] = c; chv[3] = d;
  endtask

  // Monitor: per-cycle busy/overrun against the model, scoreboard pop on every valid.
  always @(negedge clk) begin
    if (reset_n) begin
      mb = (edges >= last_acc) && (edges < last_acc + int'(CH));
      check("busy", longint'(bus.busy), longint'(mb));
      check("overrun", longint'(bus.overrun), longint'(m_ov));
      if (bus.pcm_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got pcm_valid=1, expected none (edge %0d)", edges);
        end else begin
          e = sb.pop_front();
          check("latency", longint'(edges), longint'(e.due));
          check("pcm_out", longint'(bus.pcm_out), longint'(e.val));
          check("clip", longint'(bus.clip), longint'(e.clp));
`ifdef PCM_MIX_CLIP_CNT_EN
          if (e.clp && cc_clr_edge != edges && m_cc < 65535) m_cc++;
          check("clip_count", longint'(bus.clip_count), longint'(m_cc));
`endif
        end
      end else if (sb.size() > 0 && edges > sb[0].due) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_valid: got no pcm_valid, expected one at edge %0d", sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_strobe = 1'b0;
    bus.gain_we       = 1'b0;
    bus.gain_sel      = '0;
    bus.gain_data     = '0;
    bus.overrun_clr   = 1'b0;
    bus.pcm_in        = '0;
    set_ch(0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    check("rst_pcm_out", longint'(bus.pcm_out), 0);
    check("rst_valid", longint'(bus.pcm_valid), 0);
    check("rst_clip", longint'(bus.clip), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_overrun", longint'(bus.overrun), 0);

    // Basic unity mix.
    set_ch(1000, 2000, -500, 0);
    step(1'b1);
    idle(6);
    check("t1_sum", longint'(bus.pcm_out), 2500);

    // Saturation both ways.
    set_ch(30000, 30000, 30000, 30000);
    step(1'b1);
    idle(6);
    check("t2_pos_sat", longint'(bus.pcm_out), 32767);
    set_ch(-30000, -30000, -30000, -30000);
    step(1'b1);
    idle(6);
    check("t2_neg_sat", longint'(bus.pcm_out), -32768);
`ifdef PCM_MIX_CLIP_CNT_EN
    check("t2_clip_count", longint'(bus.clip_count), 2);
`endif

    // Gain scaling, zero gain, max gain, floor rounding.
    step(1'b0, 1'b1, 0, 32);
    set_ch(1001, 0, 0, 0);
    step(1'b1);
    idle(6);
    check("t3_half", longint'(bus.pcm_out), 500);
    step(1'b0, 1'b1, 1, 0);
    set_ch(0, 20000, 0, 0);
    step(1'b1);
    idle(6);
    check("t3_zero", longint'(bus.pcm_out), 0);
    step(1'b0, 1'b1, 2, 255);
    set_ch(0, 0, 8000, 0);
    step(1'b1);
    idle(6);
    check("t3_max", longint'(bus.pcm_out), 31875);
    set_ch(-3, 0, 0, 0);
    step(1'b1);
    idle(6);
    check("t3_floor", longint'(bus.pcm_out), -2);

    // Overrun: second strobe while busy is ignored.
    set_ch(400, 0, 0, 0);
    step(1'b1);
    step(1'b0);
    set_ch(9999, 9999, 9999, 9999);
    step(1'b1);
    idle(6);
    check("t4_first_kept", longint'(bus.pcm_out), 200);
    check("t4_overrun_set", longint'(bus.overrun), 1);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    check("t4_overrun_clr", longint'(bus.overrun), 0);

    // Gain write mid-accumulation; back-to-back strobe in the valid cycle.
    set_ch(100, 0, 0, 0);
    step(1'b1);
    step(1'b0, 1'b1, 0, 0);
    idle(3);
    check("t5_first_old_gain", longint'(bus.pcm_out), 50);
    step(1'b1);
    idle(6);
    check("t5_second_new_gain", longint'(bus.pcm_out), 0);

    // Reset mid-accumulation aborts and restores unity gains.
    set_ch(5000, 5000, 5000, 5000);
    step(1'b1);
    step(1'b0);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_busy", longint'(bus.busy), 0);
    check("t6_pcm_out", longint'(bus.pcm_out), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(6);
    set_ch(1234, 1, 2, 3);
    step(1'b1);
    idle(6);
    check("t6_unity", longint'(bus.pcm_out), 1240);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < int'(CH); k++) chv[k] = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 3) == 0)
        step($urandom_range(0, 2) == 0, 1'b1, int'($urandom_range(0, CH - 1)),
             int'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
      else
        step($urandom_range(0, 2) == 0, 1'b0, 0, 0, $urandom_range(0, 9) == 0);
    end
    idle(8);
    check("sb_drained", longint'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
